// File: rtl/tilt_ball_ctrl_if.sv
// rtl/tilt_ball_ctrl_if.sv - wall-checker request/acknowledge interface for tilt_ball_ctrl
//
// Purpose: carries one candidate ball position to an external wall checker and
// brings back its verdict.
// Signals:
//   chk_req  master->slave  candidate valid, held high until chk_ack
//   chk_x    master->slave  candidate x, stable while chk_req is high
//   chk_y    master->slave  candidate y, stable while chk_req is high
//   chk_ack  slave->master  response strobe, only meaningful while chk_req is high
//   chk_ok   slave->master  1 = candidate cell is free, valid with chk_ack
interface tilt_ball_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) ();
    logic           chk_req;
    logic [X_W-1:0] chk_x;
    logic [Y_W-1:0] chk_y;
    logic           chk_ack;
    logic           chk_ok;

    modport master (output chk_req, chk_x, chk_y, input chk_ack, chk_ok);
    modport slave  (input chk_req, chk_x, chk_y, output chk_ack, chk_ok);
endinterface

// File: rtl/tilt_ball_ctrl.sv
// rtl/tilt_ball_ctrl.sv - maze ball motion controller with wall-check handshake
//
// Purpose: once per frame tick, derives per-axis acceleration from tilt or buttons,
// updates saturated velocity (with friction in tilt mode), clamps the candidate to
// the screen, asks the wall checker about it and slides along walls on denial.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mode                  0 = tilt, 1 = buttons (used only while computing a move)
//   accel_x, accel_y      signed tilt inputs
//   btn_xinc..btn_ydec    debounced direction buttons
//   chk                   wall-checker handshake (master side)
//   x_out, y_out          committed ball position
//   vel_x, vel_y          signed committed velocity
//   upd                   one-cycle pulse coincident with a new committed position
//   tick_miss             sticky flag: a frame tick arrived while busy
module tilt_ball_ctrl #(
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int ACC_W     = 9,
    parameter int X_MAX     = 319,
    parameter int Y_MAX     = 239,
    parameter int X_INIT    = 160,
    parameter int Y_INIT    = 120,
    parameter int DEAD_ZONE = 16,
    parameter int ACC_SHIFT = 4,
    parameter int VMAX      = 7,
    parameter int TICK_DIV  = 1666667
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic signed [ACC_W-1:0] accel_x,
    input  logic signed [ACC_W-1:0] accel_y,
    input  logic                    btn_xinc,
    input  logic                    btn_xdec,
    input  logic                    btn_yinc,
    input  logic                    btn_ydec,
    tilt_ball_ctrl_if.master        chk,
    output logic [X_W-1:0]          x_out,
    output logic [Y_W-1:0]          y_out,
    output logic signed [4:0]       vel_x,
    output logic signed [4:0]       vel_y,
    output logic                    upd,
    output logic                    tick_miss
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    // Two guard bits: |accel| of the most negative input and v + a both fit.
    localparam int AW = ACC_W + 2;
    localparam logic signed [AW-1:0] ZERO = '0;
    localparam logic signed [AW-1:0] ONE  = AW'(1);
    localparam logic signed [AW-1:0] VM   = AW'(VMAX);
    localparam logic signed [AW-1:0] DZ   = AW'(DEAD_ZONE);
    localparam logic signed [X_W:0]  XMAX_S = X_MAX[X_W:0];
    localparam logic signed [Y_W:0]  YMAX_S = Y_MAX[Y_W:0];

    typedef enum logic [2:0] {IDLE, CALC, CHK_XY, CHK_X, CHK_Y, COMMIT} state_t;

    // Frame tick generator
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CW'(1);
    end

    // New velocity for one axis from the current velocity and this frame's inputs.
    function automatic logic signed [4:0] vel_next(
        input logic signed [4:0]       v,
        input logic signed [ACC_W-1:0] acc,
        input logic                    inc,
        input logic                    dec,
        input logic                    btn_mode
    );
        logic signed [AW-1:0] acc_w, mag, a, vw, s;
        acc_w = {{2{acc[ACC_W-1]}}, acc};
        vw    = {{(AW-5){v[4]}}, v};
        mag   = acc_w[AW-1] ? -acc_w : acc_w;
        if (btn_mode)
            a = (inc & ~dec) ? ONE : ((dec & ~inc) ? -ONE : ZERO);
        else if (mag <= DZ)
            a = ZERO;
        else
            a = acc_w >>> ACC_SHIFT;

        if (!btn_mode && a == ZERO) begin
            // Friction: no tilt means decay one step toward rest.
            if (vw > ZERO)      s = vw - ONE;
            else if (vw < ZERO) s = vw + ONE;
            else                s = ZERO;
        end else begin
            s = vw + a;
            if (s > VM)       s = VM;
            else if (s < -VM) s = -VM;
        end
        return s[4:0];
    endfunction

    // Candidate position and velocity, valid during CALC
    logic signed [4:0] cand_vx, cand_vy;
    logic [X_W-1:0]    cand_x;
    logic [Y_W-1:0]    cand_y;
    logic signed [X_W:0] sum_x;
    logic signed [Y_W:0] sum_y;
    logic signed [4:0] vx_raw, vy_raw;

    always_comb begin
        vx_raw = vel_next(vel_x, accel_x, btn_xinc, btn_xdec, mode);
        vy_raw = vel_next(vel_y, accel_y, btn_yinc, btn_ydec, mode);
        sum_x  = $signed({1'b0, x_out}) + $signed({{(X_W-4){vx_raw[4]}}, vx_raw});
        sum_y  = $signed({1'b0, y_out}) + $signed({{(Y_W-4){vy_raw[4]}}, vy_raw});

        cand_vx = vx_raw;
        cand_x  = sum_x[X_W-1:0];
        if (sum_x[X_W]) begin
            cand_x  = '0;
            cand_vx = '0;
        end else if (sum_x > XMAX_S) begin
            cand_x  = XMAX_S[X_W-1:0];
            cand_vx = '0;
        end

        cand_vy = vy_raw;
        cand_y  = sum_y[Y_W-1:0];
        if (sum_y[Y_W]) begin
            cand_y  = '0;
            cand_vy = '0;
        end else if (sum_y > YMAX_S) begin
            cand_y  = YMAX_S[Y_W-1:0];
            cand_vy = '0;
        end
    end

    // FSM and datapath registers. nx/ny/nvx/nvy hold the proposal during the
    // checks and are overwritten with the final values once the outcome is known.
    state_t            state, state_n;
    logic              req_r, req_n;
    logic [X_W-1:0]    cx_r, cx_n, nx_r, nx_n, x_n;
    logic [Y_W-1:0]    cy_r, cy_n, ny_r, ny_n, y_n;
    logic signed [4:0] nvx_r, nvx_n, nvy_r, nvy_n, vx_n, vy_n;
    logic              upd_n, miss_n;

    assign chk.chk_req = req_r;
    assign chk.chk_x   = cx_r;
    assign chk.chk_y   = cy_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_r     <= 1'b0;
            cx_r      <= '0;
            cy_r      <= '0;
            nx_r      <= '0;
            ny_r      <= '0;
            nvx_r     <= '0;
            nvy_r     <= '0;
            x_out     <= X_INIT[X_W-1:0];
            y_out     <= Y_INIT[Y_W-1:0];
            vel_x     <= '0;
            vel_y     <= '0;
            upd       <= 1'b0;
            tick_miss <= 1'b0;
        end else begin
            state     <= state_n;
            req_r     <= req_n;
            cx_r      <= cx_n;
            cy_r      <= cy_n;
            nx_r      <= nx_n;
            ny_r      <= ny_n;
            nvx_r     <= nvx_n;
            nvy_r     <= nvy_n;
            x_out     <= x_n;
            y_out     <= y_n;
            vel_x     <= vx_n;
            vel_y     <= vy_n;
            upd       <= upd_n;
            tick_miss <= miss_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = req_r;
        cx_n    = cx_r;
        cy_n    = cy_r;
        nx_n    = nx_r;
        ny_n    = ny_r;
        nvx_n   = nvx_r;
        nvy_n   = nvy_r;
        x_n     = x_out;
        y_n     = y_out;
        vx_n    = vel_x;
        vy_n    = vel_y;
        upd_n   = 1'b0;
        miss_n  = tick_miss | (tick && state != IDLE);

        case (state)
            IDLE: if (tick) state_n = CALC;

            CALC: begin
                nx_n  = cand_x;
                ny_n  = cand_y;
                nvx_n = cand_vx;
                nvy_n = cand_vy;
                if (cand_x == x_out && cand_y == y_out) begin
                    state_n = COMMIT;
                end else begin
                    state_n = CHK_XY;
                    req_n   = 1'b1;
                    cx_n    = cand_x;
                    cy_n    = cand_y;
                end
            end

            // In every CHK state a low chk_req means we just arrived from another
            // check and owe the checker one idle cycle before asking again.
            CHK_XY: begin
                if (!req_r) begin
                    req_n = 1'b1;
                end else if (chk.chk_ack) begin
                    req_n = 1'b0;
                    if (chk.chk_ok) begin
                        state_n = COMMIT;
                    end else if (nx_r != x_out) begin
                        state_n = CHK_X;
                        cx_n    = nx_r;
                        cy_n    = y_out;
                    end else begin
                        state_n = CHK_Y;
                        cx_n    = x_out;
                        cy_n    = ny_r;
                    end
                end
            end

            CHK_X: begin
                if (!req_r) begin
                    req_n = 1'b1;
                end else if (chk.chk_ack) begin
                    req_n = 1'b0;
                    if (chk.chk_ok) begin
                        state_n = COMMIT;
                        ny_n    = y_out;
                        nvy_n   = '0;
                    end else if (ny_r != y_out) begin
                        state_n = CHK_Y;
                        cx_n    = x_out;
                        cy_n    = ny_r;
                    end else begin
                        state_n = COMMIT;
                        nx_n    = x_out;
                        ny_n    = y_out;
                        nvx_n   = '0;
                        nvy_n   = '0;
                    end
                end
            end

            CHK_Y: begin
                if (!req_r) begin
                    req_n = 1'b1;
                end else if (chk.chk_ack) begin
                    req_n   = 1'b0;
                    state_n = COMMIT;
                    nx_n    = x_out;
                    nvx_n   = '0;
                    if (!chk.chk_ok) begin
                        ny_n  = y_out;
                        nvy_n = '0;
                    end
                end
            end

            COMMIT: begin
                x_n     = nx_r;
                y_n     = ny_r;
                vx_n    = nvx_r;
                vy_n    = nvy_r;
                upd_n   = 1'b1;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tilt_ball_ctrl.sv
// tb/tb_tilt_ball_ctrl.sv - randomized self-checking bench for tilt_ball_ctrl
module tb_tilt_ball_ctrl;
    localparam int TD = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic signed [8:0] accel_x, accel_y;
    logic              btn_xinc, btn_xdec, btn_yinc, btn_ydec;
    logic [9:0]        x_out;
    logic [8:0]        y_out;
    logic signed [4:0] vel_x, vel_y;
    logic              upd, tick_miss;

    tilt_ball_ctrl_if #(.X_W(10), .Y_W(9)) chk_if ();

    tilt_ball_ctrl #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .btn_xinc  (btn_xinc),
        .btn_xdec  (btn_xdec),
        .btn_yinc  (btn_yinc),
        .btn_ydec  (btn_ydec),
        .chk       (chk_if),
        .x_out     (x_out),
        .y_out     (y_out),
        .vel_x     (vel_x),
        .vel_y     (vel_y),
        .upd       (upd),
        .tick_miss (tick_miss)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, want);
    endtask

    // Reference model state: committed ball and expected frame outcome
    int mx = 160, my = 120, mvx = 0, mvy = 0;
    int ex, ey, evx, evy;
    int exp_q[$];
    int wall_sel = 0, salt = 0, ack_dly = 1;
    int frames = 0, upd_cnt = 0;

    // Wall map: 0 open, 1 diagonal moves blocked, 2 hashed walls, 3 everything blocked
    function automatic bit wall_free(input int cx, input int cy);
        case (wall_sel)
            0:       return 1'b1;
            1:       return (cx == mx) || (cy == my);
            2:       return ((cx * 3 + cy * 5 + salt) % 4) != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int accel_of(input int acc, input bit md, input bit inc, input bit dec);
        if (md) return int'(inc) - int'(dec);
        if (acc >= -16 && acc <= 16) return 0;
        if (acc >= 0) return acc / 16;
        return -((15 - acc) / 16);
    endfunction

    function automatic int vel_of(input int v, input int a, input bit md);
        int s;
        if (!md && a == 0) return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
        s = v + a;
        if (s > 7) s = 7;
        if (s < -7) s = -7;
        return s;
    endfunction

    task automatic predict();
        int vx, vy, px, py;
        vx = vel_of(mvx, accel_of(int'(accel_x), mode, btn_xinc, btn_xdec), mode);
        vy = vel_of(mvy, accel_of(int'(accel_y), mode, btn_yinc, btn_ydec), mode);
        px = mx + vx;
        py = my + vy;
        if (px < 0) begin px = 0; vx = 0; end
        if (px > 319) begin px = 319; vx = 0; end
        if (py < 0) begin py = 0; vy = 0; end
        if (py > 239) begin py = 239; vy = 0; end
        ex = mx; ey = my; evx = 0; evy = 0;
        if (px == mx && py == my) begin
            ex = px; ey = py; evx = vx; evy = vy;
        end else begin
            exp_q.push_back(px * 1024 + py);
            if (wall_free(px, py)) begin
                ex = px; ey = py; evx = vx; evy = vy;
            end else if (px != mx) begin
                exp_q.push_back(px * 1024 + my);
                if (wall_free(px, my)) begin
                    ex = px; evx = vx;
                end else if (py != my) begin
                    exp_q.push_back(mx * 1024 + py);
                    if (wall_free(mx, py)) begin ey = py; evy = vy; end
                end
            end else begin
                exp_q.push_back(mx * 1024 + py);
                if (wall_free(mx, py)) begin ey = py; evy = vy; end
            end
        end
    endtask

    task automatic run_frame(input int budget);
        bit seen;
        seen = 1'b0;
        predict();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (upd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("upd_seen", int'(seen), 1);
        if (!seen) begin
            exp_q.delete();
            return;
        end
        check("x_out", int'(x_out), ex);
        check("y_out", int'(y_out), ey);
        check("vel_x", int'(vel_x), evx);
        check("vel_y", int'(vel_y), evy);
        check("req_left", exp_q.size(), 0);
        mx = ex; my = ey; mvx = evx; mvy = evy;
        frames++;
        @(negedge clk);
        check("upd_pulse", int'(upd), 0);
        check("upd_cnt", upd_cnt, frames);
    endtask

    always @(negedge clk) if (upd === 1'b1) upd_cnt <= upd_cnt + 1;

    // Wall checker: answers each request after ack_dly cycles, and sometimes
    // strobes ack while no request is pending.
    initial begin : responder
        int rx, ry;
        chk_if.chk_ack = 1'b0;
        chk_if.chk_ok  = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_if.chk_req === 1'b1 && reset === 1'b0) begin
                rx = int'(chk_if.chk_x);
                ry = int'(chk_if.chk_y);
                if (exp_q.size() > 0) check("req_xy", rx * 1024 + ry, exp_q.pop_front());
                else check("req_xy", rx * 1024 + ry, -1);
                repeat (ack_dly) @(negedge clk);
                check("req_held", int'(chk_if.chk_req), 1);
                check("req_stable", int'(chk_if.chk_x) * 1024 + int'(chk_if.chk_y), rx * 1024 + ry);
                chk_if.chk_ack = 1'b1;
                chk_if.chk_ok  = wall_free(rx, ry);
                @(negedge clk);
                chk_if.chk_ack = 1'b0;
                chk_if.chk_ok  = 1'($urandom_range(0, 1));
                check("req_gap", int'(chk_if.chk_req), 0);
            end else if ($urandom_range(0, 7) == 0) begin
                chk_if.chk_ack = 1'b1;
                chk_if.chk_ok  = 1'b1;
                @(negedge clk);
                chk_if.chk_ack = 1'b0;
            end
        end
    end

    function automatic logic signed [8:0] rnd_acc();
        int v;
        if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 40)) - 20;
        else v = int'($urandom_range(0, 511)) - 256;
        return 9'(v);
    endfunction

    task automatic set_inputs(input bit md, input int ax, input int ay,
                              input bit xi, input bit xd, input bit yi, input bit yd);
        mode = md; accel_x = 9'(ax); accel_y = 9'(ay);
        btn_xinc = xi; btn_xdec = xd; btn_yinc = yi; btn_ydec = yd;
    endtask

    int x_tab[8] = '{164, 171, 178, 185, 192, 199, 206, 213};
    int v_tab[8] = '{4, 7, 7, 7, 7, 7, 7, 7};
    bit seen_req;

    initial begin
        reset = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_x", int'(x_out), 160);
        check("rst_y", int'(y_out), 120);
        check("rst_vx", int'(vel_x), 0);
        check("rst_vy", int'(vel_y), 0);
        check("rst_req", int'(chk_if.chk_req), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_miss", int'(tick_miss), 0);
        reset = 1'b0;

        // Steady tilt to the right with an open maze
        set_inputs(0, 64, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_frame(200);
            check("tilt_x_tab", int'(x_out), x_tab[i]);
            check("tilt_v_tab", int'(vel_x), v_tab[i]);
        end

        // Tilt inside the dead zone: friction brings the ball to rest
        set_inputs(0, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) run_frame(200);
        check("dz_vel_x", int'(vel_x), 0);
        check("dz_x_hold", int'(x_out), 234);

        // Buttons diagonally into a wall that only allows the x slide
        wall_sel = 1;
        set_inputs(1, 0, 0, 1, 0, 1, 0);
        run_frame(200);
        check("btn_slide_x", int'(x_out), 235);
        check("btn_slide_y", int'(y_out), 120);
        check("btn_slide_vx", int'(vel_x), 1);
        check("btn_slide_vy", int'(vel_y), 0);

        // Hard tilt into the right and top screen edges
        wall_sel = 0;
        set_inputs(0, 255, -256, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) run_frame(200);
        check("edge_x", int'(x_out), 319);
        check("edge_y", int'(y_out), 0);
        check("edge_vx", int'(vel_x), 0);
        check("edge_vy", int'(vel_y), 0);

        // Random frames against random wall maps and ack latencies
        for (int i = 0; i < 40; i++) begin
            mode     = 1'($urandom_range(0, 1));
            accel_x  = rnd_acc();
            accel_y  = rnd_acc();
            btn_xinc = 1'($urandom_range(0, 1));
            btn_xdec = 1'($urandom_range(0, 1));
            btn_yinc = 1'($urandom_range(0, 1));
            btn_ydec = 1'($urandom_range(0, 1));
            wall_sel = int'($urandom_range(0, 3));
            salt     = int'($urandom_range(0, 3));
            ack_dly  = int'($urandom_range(0, 3));
            run_frame(200);
        end
        check("miss_clear", int'(tick_miss), 0);

        // Checker slower than a frame: ticks are dropped, one update per accepted tick
        wall_sel = 0;
        ack_dly  = 45;
        for (int i = 0; i < 3; i++) begin
            set_inputs(0, (mx > 160) ? -128 : 128, (my > 120) ? -128 : 128, 0, 0, 0, 0);
            run_frame(400);
        end
        check("miss_set", int'(tick_miss), 1);

        // Reset while a request is outstanding
        set_inputs(0, (mx > 160) ? -128 : 128, (my > 120) ? -128 : 128, 0, 0, 0, 0);
        predict();
        seen_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (chk_if.chk_req === 1'b1) begin
                seen_req = 1'b1;
                break;
            end
        end
        check("rst_mid_req", int'(seen_req), 1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_req_drop", int'(chk_if.chk_req), 0);
        check("rst_mid_x", int'(x_out), 160);
        check("rst_mid_y", int'(y_out), 120);
        check("rst_mid_vx", int'(vel_x), 0);
        check("rst_mid_vy", int'(vel_y), 0);
        check("rst_mid_miss", int'(tick_miss), 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
